// File: rtl/alu_issue_unit.sv
// alu_issue_unit: execute stage that issues instructions to an external
// combinational 16-bit ALU, writes results back to an 8x16 register file,
// updates zero/negative flags and presents each result on a response port.
//
// Handshakes (both ports): a transfer happens on a rising clk edge where
// valid and ready are both high. The sender holds its payload stable while
// valid is high and ready is low. instr_ready is high only in IDLE.
// res_valid is high only in WB, and res_data/res_rd stay stable until
// res_ready is seen.
module alu_issue_unit #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr,
  output logic [DATA_W-1:0] alu_in0,
  output logic [DATA_W-1:0] alu_in1,
  output logic [3:0]        alu_select,
  input  logic [DATA_W-1:0] alu_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [2:0]        res_rd,
  output logic              flag_z,
  output logic              flag_n,
  input  logic [2:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  localparam logic [3:0] OP_CMP = 4'b0111;

  state_t            r_state;
  logic [DATA_W-1:0] r_regs [NREGS];
  logic [2:0]        r_rd;
  logic [DATA_W-1:0] r_alu_in0;
  logic [DATA_W-1:0] r_alu_in1;
  logic [3:0]        r_alu_sel;
  logic [DATA_W-1:0] r_res_data;
  logic [2:0]        r_res_rd;
  logic              r_flag_z;
  logic              r_flag_n;

  // Instruction field decode
  logic [3:0]        w_op;
  logic [2:0]        w_rd;
  logic [2:0]        w_rs1;
  logic [2:0]        w_rs2;
  logic [DATA_W-1:0] w_imm;

  assign w_op  = instr[15:12];
  assign w_rd  = instr[11:9];
  assign w_rs1 = instr[8:6];
  assign w_rs2 = instr[5:3];
  assign w_imm = {{(DATA_W-6){1'b0}}, instr[5:0]};

  // Issue FSM, register file, ALU operand drive and result capture.
  // Operands are registered at accept: the register file cannot change
  // between accept and the EXEC edge, so this equals a read during EXEC,
  // and the ALU inputs naturally hold their last values outside EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      r_rd       <= '0;
      r_alu_in0  <= '0;
      r_alu_in1  <= '0;
      r_alu_sel  <= '0;
      r_res_data <= '0;
      r_res_rd   <= '0;
      r_flag_z   <= 1'b0;
      r_flag_n   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (instr_valid) begin
            r_alu_in0 <= r_regs[w_rs1];
            r_alu_in1 <= w_op[3] ? w_imm : r_regs[w_rs2];
            r_alu_sel <= w_op;
            r_rd      <= w_rd;
            r_state   <= EXEC;
          end
        end
        EXEC: begin
          r_res_data <= alu_out;
          r_res_rd   <= r_rd;
          r_flag_z   <= (alu_out == '0);
          r_flag_n   <= alu_out[DATA_W-1];
          if (r_alu_sel != OP_CMP) r_regs[r_rd] <= alu_out;
          r_state    <= WB;
        end
        WB: begin
          if (res_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign instr_ready = (r_state == IDLE);
  assign res_valid   = (r_state == WB);
  assign alu_in0     = r_alu_in0;
  assign alu_in1     = r_alu_in1;
  assign alu_select  = r_alu_sel;
  assign res_data    = r_res_data;
  assign res_rd      = r_res_rd;
  assign flag_z      = r_flag_z;
  assign flag_n      = r_flag_n;
  assign dbg_data    = r_regs[dbg_addr];
  assign dbg_state   = r_state;

endmodule

// File: doc/alu_issue_unit.md
Name: alu_issue_unit

Overview:
- Initiator/controller on the driving side of the 16-bit combinational ALU (ports in0, in1, select, out).
- Accepts 16-bit instruction words over a valid/ready handshake and reads operands from an internal 8x16 register file.
- Drives the external ALU for one cycle, captures its output, writes the result back and updates flags.
- Presents each result on a valid/ready response port; forms the execute stage of the CPU core.

Parameters:
- DATA_W, 16, ALU operand/result width.
- NREGS, 8, register file depth; register index width is 3.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  instruction word present.
- instr_ready  out  1  unit can accept an instruction.
- instr  in  16  [15:12] op, [11:9] rd, [8:6] rs1, [5:3] rs2, [5:0] imm6 when op[3]=1.
- alu_in0  out  16  to ALU in0.
- alu_in1  out  16  to ALU in1.
- alu_select  out  4  to ALU select.
- alu_out  in  16  from ALU out.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_data  out  16  captured ALU result.
- res_rd  out  3  destination index; for CMP, the rd field as issued.
- flag_z  out  1  last result == 0.
- flag_n  out  1  last result bit 15.
- dbg_addr  in  3  register file debug read address.
- dbg_data  out  16  combinational read of reg[dbg_addr].

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; all 8 registers = 0; flag_z = 0, flag_n = 0.
  - res_valid = 0, res_data = 0, res_rd = 0.
  - alu_in0 = 0, alu_in1 = 0, alu_select = 0.
  - instr_ready = 1 after rst_n deasserts.
- ALU op encoding driven on alu_select = op:
  - 0000 add; 0001 sub; 0010 in0<<in1; 0011 in0>>in1 (logical); 0100 and; 0101 or; 0110 xor.
  - 0111 CMP: sub, flags only, no register write.
  - 1xxx: ALU passes in1, i.e. load immediate.
- States:
  - IDLE: instr_ready = 1. On instr_valid & instr_ready, latch instr, go to EXEC.
  - EXEC: instr_ready = 0.
    - alu_in0 = reg[rs1].
    - alu_in1 = reg[rs2], or {10'b0, imm6} when op[3]=1.
    - alu_select = op.
    - On the clock edge: res_data <= alu_out; res_rd <= rd; flag_z <= (alu_out==0); flag_n <= alu_out[15].
    - Same edge: reg[rd] <= alu_out unless op==0111.
    - Go to WB.
  - WB: res_valid = 1, instr_ready = 0. On res_ready go to IDLE; res_valid drops the next cycle. Otherwise hold and keep res_data/res_rd stable.
- ALU output drive outside EXEC: alu_in0/alu_in1/alu_select hold their last EXEC values. Only alu_out sampled at the EXEC edge is meaningful.
- Latency: instruction accepted at edge N.
  - ALU driven during cycle N+1.
  - Regfile, flags and res_data updated at edge N+2; res_valid high from N+2.
  - Minimum issue interval is 3 cycles with res_ready held high.
- Operand hazards: none. Writeback completes before IDLE, so a back-to-back dependent instruction reads the new value.
- rs1==rd or rs2==rd: operands are read before the write; the old value is used.
- Shift amounts >= 16 give 0 (ALU semantics); the unit does not clamp.
- Arithmetic wraps modulo 2^16. No carry flag.
- dbg_data is purely combinational and reflects a write from the cycle after the EXEC edge.
- Reset mid-EXEC or mid-WB:
  - Instruction abandoned, no register write, result discarded.
  - All state returns to reset values immediately.
- instr_valid while not ready: ignored. The instruction must be held by the sender (standard valid/ready).

Test Plan:
- Load immediates: op=1000 rd=1 imm=13, then op=1000 rd=2 imm=4 -> dbg reg1=13, reg2=4; res_data 13 then 4; each res_valid 2 cycles after accept.
- With r1=13, r2=4, issue ops 0000..0110 rd=3 rs1=1 rs2=2 -> res_data 17, 9, 208, 0, 4, 13, 9 respectively; reg3 matches; flag_z=1 only for the shr (0).
- CMP op=0111 rd=5 rs1=1 rs2=1 with reg5 preloaded to 7 -> res_data 0, flag_z=1, flag_n=0, reg5 still 7; then op=0001 rs1=2 rs2=1 -> 0xFFF7, flag_n=1.
- Backpressure: hold res_ready=0 for 3 cycles in WB -> res_valid stays 1, res_data stable, instr_ready=0; release -> IDLE next cycle, next instruction accepted.
- Dependent issue: r4 = r1+r2 immediately followed by r4 = r4+r4 -> reg4 = 34.
- Assert rst_n=0 during EXEC of op=1000 rd=6 imm=63 -> reg6=0, res_valid=0, flags 0, instr_ready=1 after release.
